xadac_axi_mem: RTL and testbench

- Single-beat AXI4 responder (slave) memory that answers the XADAC vector unit's AXI master port.
- Serves vload reads (AR/R) and vactv writes (AW/W/B), each carrying one full VecDataWidth beat (len=0, size=log2(VecDataWidth/8)).
- Used as on-chip vector scratchpad and as the bench-side memory model behind the xadac top.

---
 rtl/xadac_pkg.sv | 20 ++
 rtl/xadac_axi_mem_bank.sv | 41 ++++
 rtl/xadac_axi_mem.sv | 165 ++++++++++++++++
 tb/tb_xadac_axi_mem.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xadac_pkg.sv
// xadac_pkg: shared types and constants for the XADAC vector unit AXI side.
// Contents:
//   IdT, AddrT        - AXI ID and address types
//   VecDataT, VecStrbT - one vector beat and its byte enables
//   RespT             - AXI response code, with RespOkay / RespSlvErr
package xadac_pkg;

    localparam int VecDataWidth = 128;
    localparam int VecStrbWidth = VecDataWidth / 8;

    typedef logic [3:0]              IdT;
    typedef logic [63:0]             AddrT;
    typedef logic [VecDataWidth-1:0] VecDataT;
    typedef logic [VecStrbWidth-1:0] VecStrbT;

    typedef logic [1:0] RespT;
    localparam RespT RespOkay   = 2'b00;
    localparam RespT RespSlvErr = 2'b10;

endpackage

// File: rtl/xadac_axi_mem_bank.sv
// xadac_axi_mem_bank: Depth x DataWidth simple dual-port RAM.
// One synchronous read port and one byte-enabled write port. A read and a
// write to the same word on the same edge return the old contents.
// Ports:
//   clk            clock
//   re, raddr      read enable / word index; rdata valid the cycle after re
//   rdata          registered read data (holds when re is low)
//   we, waddr      write enable / word index
//   wdata, wstrb   write data and byte enables
module xadac_axi_mem_bank #(
    parameter int Depth     = 1024,
    parameter int DataWidth = 128,
    parameter int IdxW      = $clog2(Depth)
) (
    input  logic                   clk,
    input  logic                   re,
    input  logic [IdxW-1:0]        raddr,
    output logic [DataWidth-1:0]   rdata,
    input  logic                   we,
    input  logic [IdxW-1:0]        waddr,
    input  logic [DataWidth-1:0]   wdata,
    input  logic [DataWidth/8-1:0] wstrb
);

    logic [DataWidth-1:0] mem [Depth];

    // Contents are deliberately not reset; rdata holds during read stalls.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
        if (we) begin
            for (int i = 0; i < DataWidth / 8; i++) begin
                if (wstrb[i]) begin
                    mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/xadac_axi_mem.sv
// xadac_axi_mem: single-beat AXI4 responder memory for the XADAC vector unit.
// Serves one full-width read beat (AR/R) or write beat (AW/W/B) per burst.
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   aw_id/aw_addr/aw_valid/aw_ready   write address channel
//   w_data/w_strb/w_valid/w_ready     write data channel
//   b_id/b_resp/b_valid/b_ready       write response channel
//   ar_id/ar_addr/ar_valid/ar_ready   read address channel
//   r_id/r_data/r_resp/r_last/r_valid/r_ready  read data channel
// Handshake: a beat transfers on a rising edge where valid && ready; a
// raised valid keeps its payload stable until that edge.
// Build option: define XADAC_AXI_MEM_ERR_EN to flag addresses with bits set
// above the memory range as SLVERR (writes suppressed, reads return zero).
// Without it, addresses wrap modulo Depth words and responses are OKAY.
module xadac_axi_mem
    import xadac_pkg::*;
#(
    parameter int IdWidth   = $bits(IdT),
    parameter int AddrWidth = $bits(AddrT),
    parameter int DataWidth = VecDataWidth,
    parameter int Depth     = 1024
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [IdWidth-1:0]     aw_id,
    input  logic [AddrWidth-1:0]   aw_addr,
    input  logic                   aw_valid,
    output logic                   aw_ready,
    input  logic [DataWidth-1:0]   w_data,
    input  logic [DataWidth/8-1:0] w_strb,
    input  logic                   w_valid,
    output logic                   w_ready,
    output logic [IdWidth-1:0]     b_id,
    output logic [1:0]             b_resp,
    output logic                   b_valid,
    input  logic                   b_ready,
    input  logic [IdWidth-1:0]     ar_id,
    input  logic [AddrWidth-1:0]   ar_addr,
    input  logic                   ar_valid,
    output logic                   ar_ready,
    output logic [IdWidth-1:0]     r_id,
    output logic [DataWidth-1:0]   r_data,
    output logic [1:0]             r_resp,
    output logic                   r_last,
    output logic                   r_valid,
    input  logic                   r_ready
);

    localparam int StrbW = DataWidth / 8;
    localparam int OffW  = $clog2(StrbW);
    localparam int IdxW  = $clog2(Depth);

    logic                 aw_held, aw_err_q;
    logic [IdWidth-1:0]   aw_id_q;
    logic [IdxW-1:0]      aw_idx_q;
    logic                 w_held;
    logic [DataWidth-1:0] w_data_q;
    logic [StrbW-1:0]     w_strb_q;
    logic                 r_err;
    logic [DataWidth-1:0] bank_rdata;

    logic aw_hs, w_hs, ar_hs, commit, aw_err, ar_err;
    logic unused_addr_bits;

`ifdef XADAC_AXI_MEM_ERR_EN
    assign aw_err = |aw_addr[AddrWidth-1:OffW+IdxW];
    assign ar_err = |ar_addr[AddrWidth-1:OffW+IdxW];
    assign unused_addr_bits = ^{aw_addr[OffW-1:0], ar_addr[OffW-1:0]};
`else
    assign aw_err = 1'b0;
    assign ar_err = 1'b0;
    assign unused_addr_bits = ^{aw_addr[OffW-1:0], ar_addr[OffW-1:0],
                                aw_addr[AddrWidth-1:OffW+IdxW],
                                ar_addr[AddrWidth-1:OffW+IdxW]};
`endif

    assign aw_ready = !aw_held;
    assign w_ready  = !w_held;
    assign ar_ready = !r_valid || r_ready;

    assign aw_hs = aw_valid && aw_ready;
    assign w_hs  = w_valid && w_ready;
    assign ar_hs = ar_valid && ar_ready;
    // A commit may share its edge with the B handshake of the previous write.
    assign commit = aw_held && w_held && (!b_valid || b_ready);

    // aw_hs and commit are mutually exclusive (one needs !aw_held, the other aw_held).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_held  <= 1'b0;
            aw_id_q  <= '0;
            aw_idx_q <= '0;
            aw_err_q <= 1'b0;
        end else if (aw_hs) begin
            aw_held  <= 1'b1;
            aw_id_q  <= aw_id;
            aw_idx_q <= aw_addr[OffW +: IdxW];
            aw_err_q <= aw_err;
        end else if (commit) begin
            aw_held  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_held   <= 1'b0;
            w_data_q <= '0;
            w_strb_q <= '0;
        end else if (w_hs) begin
            w_held   <= 1'b1;
            w_data_q <= w_data;
            w_strb_q <= w_strb;
        end else if (commit) begin
            w_held   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            b_valid <= 1'b0;
            b_id    <= '0;
            b_resp  <= RespOkay;
        end else if (commit) begin
            b_valid <= 1'b1;
            b_id    <= aw_id_q;
            b_resp  <= aw_err_q ? RespSlvErr : RespOkay;
        end else if (b_ready) begin
            b_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= 1'b0;
            r_id    <= '0;
            r_err   <= 1'b0;
        end else if (ar_hs) begin
            r_valid <= 1'b1;
            r_id    <= ar_id;
            r_err   <= ar_err;
        end else if (r_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign r_data = r_err ? '0 : bank_rdata;
    assign r_resp = r_err ? RespSlvErr : RespOkay;
    assign r_last = 1'b1;

    xadac_axi_mem_bank #(
        .Depth     (Depth),
        .DataWidth (DataWidth),
        .IdxW      (IdxW)
    ) u_bank (
        .clk   (clk),
        .re    (ar_hs),
        .raddr (ar_addr[OffW +: IdxW]),
        .rdata (bank_rdata),
        .we    (commit && !aw_err_q),
        .waddr (aw_idx_q),
        .wdata (w_data_q),
        .wstrb (w_strb_q)
    );

endmodule

// File: tb/tb_xadac_axi_mem.sv
// tb_xadac_axi_mem: self-checking bench for xadac_axi_mem (default build,
// addresses wrap). Drives inputs #1 after rising edges, samples on falling
// edges; a word-level memory model feeds expected read data and B responses
// into queues that a falling-edge monitor pops on each handshake.
module tb_xadac_axi_mem;

    localparam int DW    = 128;
    localparam int AW    = 64;
    localparam int IW    = 4;
    localparam int DEPTH = 1024;
    localparam logic [15:0] ONES = 16'hFFFF;

    logic          clk, rstn;
    logic [IW-1:0] aw_id, b_id, ar_id, r_id;
    logic [AW-1:0] aw_addr, ar_addr;
    logic          aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
    logic          ar_valid, ar_ready, r_valid, r_ready, r_last;
    logic [DW-1:0] w_data, r_data;
    logic [15:0]   w_strb;
    logic [1:0]    b_resp, r_resp;

    xadac_axi_mem #(.IdWidth(IW), .AddrWidth(AW), .DataWidth(DW), .Depth(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .aw_id(aw_id), .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
        .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
        .ar_id(ar_id), .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
        .r_valid(r_valid), .r_ready(r_ready)
    );

    // ---------------- clock / reset ----------------
    int cyc = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [DW-1:0] mem_model [DEPTH];
    logic [DW-1:0] exp_q[$];
    logic [IW-1:0] exp_rid_q[$];
    logic [IW-1:0] exp_bid_q[$];
    logic [1:0]    exp_bresp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [AW-1:0] a);
        return int'(a[13:4]);
    endfunction

    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [15:0] s);
        for (int i = 0; i < 16; i++) begin
            if (s[i]) mem_model[idx_of(a)][i*8 +: 8] = d[i*8 +: 8];
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (r_valid) begin
                if (exp_q.size() == 0) begin
                    check("r_unexpected", 1'b1, 1'b0);
                end else begin
                    check("r_id", r_id, exp_rid_q[0]);
                    check("r_data", r_data, exp_q[0]);
                    check("r_resp", r_resp, 2'b00);
                    check("r_last", r_last, 1'b1);
                    if (r_ready) begin
                        void'(exp_q.pop_front());
                        void'(exp_rid_q.pop_front());
                    end
                end
            end
            if (b_valid) begin
                if (exp_bid_q.size() == 0) begin
                    check("b_unexpected", 1'b1, 1'b0);
                end else begin
                    check("b_id", b_id, exp_bid_q[0]);
                    check("b_resp", b_resp, exp_bresp_q[0]);
                    if (b_ready) begin
                        void'(exp_bid_q.pop_front());
                        void'(exp_bresp_q.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [IW-1:0] id, input logic [AW-1:0] a);
        bit ok = 0;
        aw_id = id; aw_addr = a; aw_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (aw_ready) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        aw_valid = 1'b0;
        if (!ok) check("aw_timeout", 1'b0, 1'b1);
    endtask

    task automatic send_w(input logic [DW-1:0] d, input logic [15:0] s);
        bit ok = 0;
        w_data = d; w_strb = s; w_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (w_ready) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        w_valid = 1'b0;
        if (!ok) check("w_timeout", 1'b0, 1'b1);
    endtask

    // Expected data is taken from the model at the moment the AR is accepted.
    task automatic send_ar(input logic [IW-1:0] id, input logic [AW-1:0] a);
        bit ok = 0;
        ar_id = id; ar_addr = a; ar_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (ar_ready) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (ok) begin
            exp_q.push_back(mem_model[idx_of(a)]);
            exp_rid_q.push_back(id);
        end
        @(posedge clk); #1;
        ar_valid = 1'b0;
        if (!ok) check("ar_timeout", 1'b0, 1'b1);
    endtask

    task automatic push_b(input logic [IW-1:0] id, input logic [1:0] resp);
        exp_bid_q.push_back(id);
        exp_bresp_q.push_back(resp);
    endtask

    // Full write with b_ready held high; checks B latency (accept T, b_valid after T+1).
    task automatic do_write(input logic [IW-1:0] id, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [15:0] s);
        push_b(id, 2'b00);
        fork
            begin send_aw(id, a); end
            begin send_w(d, s); end
        join
        @(negedge clk); check("b_latency_early", b_valid, 1'b0);
        @(posedge clk); #1;
        @(negedge clk); check("b_latency_up", b_valid, 1'b1);
        @(posedge clk); #1;
        model_write(a, d, s);
    endtask

    task automatic drain();
        for (int n = 0; n < 200; n++) begin
            if (exp_q.size() == 0 && exp_bid_q.size() == 0) break;
            @(posedge clk);
        end
        #1;
        check("drain", DW'(exp_q.size() + exp_bid_q.size()), '0);
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] d1, da, db, dc, d80, d90a, d90b, de;
        int start;
        logic [7:0] pat;
        d1 = 128'h00112233445566778899AABBCCDDEEFF;
        da = rnd128(); db = rnd128(); dc = rnd128();
        d80 = rnd128(); d90a = rnd128(); d90b = rnd128(); de = rnd128();

        rstn = 1'b0;
        aw_id = '0; aw_addr = '0; aw_valid = 1'b0;
        w_data = '0; w_strb = '0; w_valid = 1'b0;
        ar_id = '0; ar_addr = '0; ar_valid = 1'b0;
        b_ready = 1'b1; r_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_aw_ready", aw_ready, 1'b1);
        check("rst_w_ready", w_ready, 1'b1);
        check("rst_ar_ready", ar_ready, 1'b1);
        check("rst_b_valid", b_valid, 1'b0);
        check("rst_r_valid", r_valid, 1'b0);
        check("rst_b_id", b_id, '0);
        check("rst_r_id", r_id, '0);
        check("rst_b_resp", b_resp, 2'b00);
        check("rst_r_resp", r_resp, 2'b00);
        @(posedge clk); #1;
        rstn = 1'b1;
        wait_cycles(1);

        // Write then read
        do_write(4'd3, 64'h40, d1, ONES);
        send_ar(4'd7, 64'h40);
        drain();

        // Strobe merge
        do_write(4'd1, 64'h0, {DW{1'b1}}, ONES);
        do_write(4'd2, 64'h0, '0, 16'h0001);
        send_ar(4'd3, 64'h0);
        drain();

        // Prewrites for later tests
        do_write(4'd4, 64'h10, da, ONES);
        do_write(4'd5, 64'h90, d90a, ONES);
        for (int i = 0; i < 4; i++) do_write(IW'(i), AW'(64'h100 + 16 * i), rnd128(), ONES);
        drain();

        // Order and backpressure: W ahead of AW, B held off
        b_ready = 1'b0;
        push_b(4'd5, 2'b00);
        send_w(d80, ONES);
        wait_cycles(2);
        send_aw(4'd5, 64'h80);
        wait_cycles(1);
        model_write(64'h80, d80, ONES);
        push_b(4'd6, 2'b00);
        fork
            begin send_aw(4'd6, 64'h90); end
            begin send_w(d90b, ONES); end
        join
        @(negedge clk);
        check("bp_aw_ready", aw_ready, 1'b0);
        check("bp_w_ready", w_ready, 1'b0);
        check("bp_b_valid", b_valid, 1'b1);
        @(posedge clk); #1;
        send_ar(4'd7, 64'h90);   // second write still held: old data
        wait_cycles(2);
        b_ready = 1'b1;
        wait_cycles(3);
        model_write(64'h90, d90b, ONES);
        send_ar(4'd8, 64'h90);
        send_ar(4'd9, 64'h80);
        drain();

        // Read stall: r_ready 1,0,0,1 then high
        pat = 8'b1111_1001;
        fork
            begin
                for (int i = 1; i <= 4; i++) send_ar(IW'(i), AW'(64'h100 + 16 * (i - 1)));
            end
            begin
                for (int k = 0; k < 8; k++) begin
                    r_ready = pat[k];
                    @(posedge clk); #1;
                end
                r_ready = 1'b1;
            end
        join
        drain();

        // Throughput with r_ready high
        start = cyc;
        for (int i = 0; i < 4; i++) send_ar(IW'(i + 8), AW'(64'h130 - 16 * i));
        check("ar_throughput", DW'(cyc - start), DW'(4));
        drain();

        // Collision: AR lands on the commit edge and sees old data
        push_b(4'd9, 2'b00);
        fork
            begin send_aw(4'd9, 64'h10); end
            begin send_w(db, ONES); end
            begin @(posedge clk); #1; send_ar(4'd10, 64'h10); end
        join
        model_write(64'h10, db, ONES);
        wait_cycles(2);
        send_ar(4'd11, 64'h10);
        drain();

        // Wrap: Depth*16 + 0x10 aliases 0x10
        do_write(4'd12, 64'h4010, dc, ONES);
        send_ar(4'd13, 64'h10);
        send_ar(4'd14, 64'hFFFF_0000_0000_0010);
        drain();

        // Reset mid-operation: AW held, R stalled
        r_ready = 1'b0;
        send_aw(4'd2, 64'h200);
        send_ar(4'd4, 64'h40);
        #1 rstn = 1'b0;
        #1;
        check("mid_rst_r_valid", r_valid, 1'b0);
        check("mid_rst_b_valid", b_valid, 1'b0);
        check("mid_rst_aw_ready", aw_ready, 1'b1);
        check("mid_rst_w_ready", w_ready, 1'b1);
        check("mid_rst_ar_ready", ar_ready, 1'b1);
        exp_q.delete(); exp_rid_q.delete();
        exp_bid_q.delete(); exp_bresp_q.delete();
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;
        r_ready = 1'b1;
        wait_cycles(1);
        send_ar(4'd5, 64'h40);
        do_write(4'd6, 64'h200, de, ONES);
        send_ar(4'd7, 64'h200);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
